fifo_flush_ctrl: RTL and testbench

Read-side scheduler for the 4-bit-in / 32-bit-out flushable FIFO. It drains 32-bit words into a downstream valid/ready consumer through a one-entry output register. It also issues flush requests to the FIFO, either when software asks or when partial data has sat idle for a programmable number of cycles. It owns the FIFO's `rd_valid`/`flush` handshake so no other block drives it.

---
 rtl/fifo_flush_pkg.sv | 15 +
 rtl/flush_idle_timer.sv | 36 +++
 rtl/fifo_flush_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_flush_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flush_pkg.sv
// Shared types and geometry for the 4-bit-in / 32-bit-out flushable FIFO
// and its read-side scheduler.
package fifo_flush_pkg;

  localparam int FIFO_RD_WIDTH = 32;
  localparam int FIFO_WR_WIDTH = 4;
  localparam int FIFO_BITS     = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/flush_idle_timer.sv
// Saturating stall counter; expired asserts once IDLE_TIMEOUT consecutive
// enabled cycles have been seen. Never expires when IDLE_TIMEOUT is 0.
module flush_idle_timer #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  generate
    if (IDLE_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [TW-1:0] TC = TW'(IDLE_TIMEOUT);
      logic [TW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en && (r_cnt != TC)) begin
          r_cnt <= r_cnt + TW'(1);
        end
      end

      assign expired = (r_cnt == TC);
    end
  endgenerate

endmodule

// File: rtl/fifo_flush_ctrl.sv
// Read-side scheduler: drains FIFO words through a one-entry output register
// and sequences software / idle-timeout flush requests to the FIFO.
//   state | meaning
//   IDLE  | normal draining; waits for pending request or idle timeout
//   FLUSH | fifo_flush_o held high until the FIFO reports completion
//   DONE  | one cycle: retire flush, pulse flush_done_o, bump counter
module fifo_flush_ctrl
  import fifo_flush_pkg::*;
#(
  parameter int RD_WIDTH     = FIFO_RD_WIDTH,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_data_avail_i,
  input  logic                 fifo_empty_i,
  input  logic [RD_WIDTH-1:0]  fifo_rd_data_i,
  input  logic                 fifo_flush_done_i,
  output logic                 fifo_rd_valid_o,
  output logic                 fifo_flush_o,
  input  logic                 flush_req_i,
  output logic                 out_valid_o,
  output logic [RD_WIDTH-1:0]  out_data_o,
  input  logic                 out_ready_i,
  output logic                 flush_busy_o,
  output logic                 flush_done_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  flush_state_e         r_state;
  flush_state_e         w_state_nxt;
  logic                 r_pending;
  logic                 r_flush;
  logic                 r_done;
  logic                 r_out_valid;
  logic [RD_WIDTH-1:0]  r_out_data;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_rd;
  logic                 w_enter_flush;
  logic                 w_noop;
  logic                 w_stall;
  logic                 w_expired;

  // Gated by rst so no word is popped while the scheduler is held in reset.
  assign w_rd    = rst && fifo_data_avail_i && (!r_out_valid || out_ready_i);
  assign w_stall = (r_state == IDLE) && !fifo_empty_i && !fifo_data_avail_i;

  flush_idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (w_stall),
    .clr     (!w_stall),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_enter_flush = 1'b0;
    w_noop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if ((r_pending || w_expired) && !fifo_empty_i) begin
          w_state_nxt   = FLUSH;
          w_enter_flush = 1'b1;
        end else if (r_pending && fifo_empty_i) begin
          w_noop = 1'b1;
        end
      end
      FLUSH: begin
        if (fifo_flush_done_i) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_flush   <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= (w_state_nxt == FLUSH);
      r_done  <= (w_state_nxt == DONE) || w_noop;
      // Entry to FLUSH absorbs a same-cycle request into the flush starting now.
      if (w_enter_flush) begin
        r_pending <= 1'b0;
      end else if (flush_req_i) begin
        r_pending <= 1'b1;
      end else if (w_noop) begin
        r_pending <= 1'b0;
      end
      if (w_state_nxt == DONE) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_rd) begin
      r_out_valid <= 1'b1;
      r_out_data  <= fifo_rd_data_i;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign fifo_rd_valid_o = w_rd;
  assign fifo_flush_o    = r_flush;
  assign out_valid_o     = r_out_valid;
  assign out_data_o      = r_out_data;
  assign flush_done_o    = r_done;
  assign flush_cnt_o     = r_cnt;
  assign flush_busy_o    = r_pending || (r_state != IDLE);

endmodule

// File: tb/tb_fifo_flush_ctrl.sv
// Directed bench for fifo_flush_ctrl: per-cycle vector table for draining,
// backpressure, no-op and software flush, plus sequences for timeout/reset.
module tb_fifo_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        avail, empty, done_i, req, ready;
  logic [31:0] rd_data;
  logic        rd_valid, flush, out_valid, busy, done_o;
  logic [31:0] out_data;
  logic [7:0]  cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_flush_ctrl #(
    .RD_WIDTH(32),
    .IDLE_TIMEOUT(8),
    .CNT_WIDTH(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_data_avail_i(avail),
    .fifo_empty_i     (empty),
    .fifo_rd_data_i   (rd_data),
    .fifo_flush_done_i(done_i),
    .fifo_rd_valid_o  (rd_valid),
    .fifo_flush_o     (flush),
    .flush_req_i      (req),
    .out_valid_o      (out_valid),
    .out_data_o       (out_data),
    .out_ready_i      (ready),
    .flush_busy_o     (busy),
    .flush_done_o     (done_o),
    .flush_cnt_o      (cnt)
  );

  typedef struct {
    logic        avail, empty;
    logic [31:0] data;
    logic        done_i, req, ready;
    logic        e_rd, e_ov;
    logic [31:0] e_od;
    logic        e_fl, e_dn, e_busy;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic a, logic e, logic [31:0] d, logic di, logic rq,
                              logic rdy, logic xrd, logic xov, logic [31:0] xod,
                              logic xfl, logic xdn, logic xbusy, logic [7:0] xcnt);
    vec_t v;
    v.avail = a;   v.empty = e;  v.data = d;    v.done_i = di; v.req = rq;
    v.ready = rdy; v.e_rd = xrd; v.e_ov = xov;  v.e_od = xod;  v.e_fl = xfl;
    v.e_dn = xdn;  v.e_busy = xbusy; v.e_cnt = xcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a, input logic e, input logic [31:0] d,
                       input logic di, input logic rq, input logic rdy);
    avail = a; empty = e; rd_data = d; done_i = di; req = rq; ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // streaming drain
    vecs[0]  = mk(1,0,32'h11111111,0,0,1, 1,0,32'h0,       0,0,0,0);
    vecs[1]  = mk(1,0,32'h22222222,0,0,1, 1,1,32'h11111111,0,0,0,0);
    vecs[2]  = mk(1,0,32'h33333333,0,0,1, 1,1,32'h22222222,0,0,0,0);
    vecs[3]  = mk(1,0,32'h44444444,0,0,1, 1,1,32'h33333333,0,0,0,0);
    vecs[4]  = mk(0,1,32'h0,       0,0,1, 0,1,32'h44444444,0,0,0,0);
    vecs[5]  = mk(0,1,32'h0,       0,0,1, 0,0,32'h44444444,0,0,0,0);
    // backpressure
    vecs[6]  = mk(1,0,32'h11111111,0,0,0, 1,0,32'h44444444,0,0,0,0);
    vecs[7]  = mk(1,0,32'h55555555,0,0,0, 0,1,32'h11111111,0,0,0,0);
    vecs[8]  = mk(1,0,32'h55555555,0,0,0, 0,1,32'h11111111,0,0,0,0);
    vecs[9]  = mk(1,0,32'h22222222,0,0,1, 1,1,32'h11111111,0,0,0,0);
    vecs[10] = mk(0,1,32'h0,       0,0,1, 0,1,32'h22222222,0,0,0,0);
    vecs[11] = mk(0,1,32'h0,       0,0,1, 0,0,32'h22222222,0,0,0,0);
    // no-op request on empty FIFO
    vecs[12] = mk(0,1,32'h0,       0,1,1, 0,0,32'h22222222,0,0,0,0);
    vecs[13] = mk(0,1,32'h0,       0,0,1, 0,0,32'h22222222,0,0,1,0);
    vecs[14] = mk(0,1,32'h0,       0,0,1, 0,0,32'h22222222,0,1,0,0);
    vecs[15] = mk(0,1,32'h0,       0,0,1, 0,0,32'h22222222,0,0,0,0);
    // software flush, request at row 16 = cycle 0
    vecs[16] = mk(0,0,32'h0,       0,1,1, 0,0,32'h22222222,0,0,0,0);
    vecs[17] = mk(0,0,32'h0,       0,0,1, 0,0,32'h22222222,0,0,1,0);
    vecs[18] = mk(0,0,32'h0,       0,0,1, 0,0,32'h22222222,1,0,1,0);
    vecs[19] = mk(1,0,32'h00000ABC,0,0,1, 1,0,32'h22222222,1,0,1,0);
    vecs[20] = mk(0,1,32'h0,       0,0,1, 0,1,32'h00000ABC,1,0,1,0);
    vecs[21] = mk(0,1,32'h0,       1,0,1, 0,0,32'h00000ABC,1,0,1,0);
    vecs[22] = mk(0,1,32'h0,       0,0,1, 0,0,32'h00000ABC,0,1,1,1);
    vecs[23] = mk(0,1,32'h0,       0,0,1, 0,0,32'h00000ABC,0,0,0,1);

    // reset state, with avail high to confirm no read happens in reset
    drive(1, 0, 32'hCAFEF00D, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid",  rd_valid,  0);
    chk("rst_flush",     flush,     0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_done",      done_o,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_cnt",       cnt,       0);
    drive(0, 1, 32'h0, 0, 0, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].avail, vecs[i].empty, vecs[i].data, vecs[i].done_i,
            vecs[i].req, vecs[i].ready);
      @(negedge clk);
      chk($sformatf("v%0d_rd_valid", i),  rd_valid,  vecs[i].e_rd);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_out_data", i),  out_data,  vecs[i].e_od);
      chk($sformatf("v%0d_flush", i),     flush,     vecs[i].e_fl);
      chk($sformatf("v%0d_done", i),      done_o,    vecs[i].e_dn);
      chk($sformatf("v%0d_busy", i),      busy,      vecs[i].e_busy);
      chk($sformatf("v%0d_cnt", i),       cnt,       vecs[i].e_cnt);
      next_cycle();
    end

    // auto-flush, stall broken by one avail cycle at cycle 5: restart -> rise at 15
    for (int k = 0; k < 16; k++) begin
      drive((k == 5), 0, 32'hA5A50000 + k, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("autoA_c%0d_flush", k), flush, (k >= 15));
      next_cycle();
    end
    drive(0, 1, 32'h0, 1, 0, 1);
    @(negedge clk);
    chk("autoA_hold_flush", flush, 1);
    next_cycle();
    drive(0, 1, 32'h0, 0, 0, 1);
    @(negedge clk);
    chk("autoA_done", done_o, 1);
    chk("autoA_flush_low", flush, 0);
    chk("autoA_cnt", cnt, 2);
    next_cycle();

    // auto-flush, continuous stall: rise at cycle 9
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 32'h0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("autoB_c%0d_flush", k), flush, (k == 9));
      chk($sformatf("autoB_c%0d_busy", k),  busy,  (k == 9));
      next_cycle();
    end
    drive(0, 0, 32'h0, 1, 0, 1);
    @(negedge clk);
    chk("autoB_c10_flush", flush, 1);
    next_cycle();
    // request arriving during DONE becomes a fresh flush after one low cycle
    drive(0, 0, 32'h0, 0, 1, 1);
    @(negedge clk);
    chk("reqdone_done", done_o, 1);
    chk("reqdone_flush", flush, 0);
    chk("reqdone_cnt", cnt, 3);
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 1);
    @(negedge clk);
    chk("reqdone_gap_flush", flush, 0);
    chk("reqdone_gap_busy", busy, 1);
    chk("reqdone_gap_done", done_o, 0);
    next_cycle();
    drive(1, 0, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clk);
    chk("reqdone_reflush", flush, 1);
    chk("reqdone_rd", rd_valid, 1);
    next_cycle();

    // reset mid-flush
    chk("midrst_pre_ov", out_valid, 1);
    chk("midrst_pre_od", out_data, 32'hDEADBEEF);
    chk("midrst_pre_flush", flush, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_flush", flush, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_cnt", cnt, 0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h0, (k == 0), 0, 1);
      @(negedge clk);
      chk($sformatf("postrst_c%0d_done", k), done_o, 0);
      chk($sformatf("postrst_c%0d_flush", k), flush, 0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
